// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcode map, FSM states and flag bit positions for alu_seq.
// The DIV state only exists when ALU_SEQ_DIV_EN is defined.
package alu_seq_pkg;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_SHL, OP_SHR,
    OP_AND, OP_OR, OP_XOR, OP_XNOR, OP_NAND, OP_NOR
  } op_t;
  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
`ifdef ALU_SEQ_DIV_EN
    S_DIV,
`endif
    S_DONE
  } state_t;
  localparam int FLG_ZERO   = 0;
  localparam int FLG_CARRY  = 1;
  localparam int FLG_OVF    = 2;
  localparam int FLG_BORROW = 3;
endpackage

// File: rtl/alu_seq_iter.sv
// alu_seq_iter: WIDTH-cycle shift-add multiplier and (with ALU_SEQ_DIV_EN) restoring divider.
// o_lo/o_hi carry the value the registers take on this edge, so they hold the final result while o_done is high.
module alu_seq_iter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
`ifdef ALU_SEQ_DIV_EN
  input  logic             i_div,
  output logic             o_dz,
`endif
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_hi
);
  localparam int CW = $clog2(WIDTH);
  logic             r_busy;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc, r_q, r_b;
  logic [WIDTH:0]   w_msum;
  logic [WIDTH-1:0] w_acc, w_q;
  assign w_msum = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : '0);
`ifdef ALU_SEQ_DIV_EN
  logic           r_div;
  logic [WIDTH:0] w_sh;
  logic           w_ge;
  // b=0 never restores, so the quotient fills with ones and a shifts intact into the remainder
  assign w_sh  = {r_acc, r_q[WIDTH-1]};
  assign w_ge  = w_sh >= {1'b0, r_b};
  assign w_acc = r_div ? (w_ge ? w_sh[WIDTH-1:0] - r_b : w_sh[WIDTH-1:0]) : w_msum[WIDTH:1];
  assign w_q   = r_div ? {r_q[WIDTH-2:0], w_ge} : {w_msum[0], r_q[WIDTH-1:1]};
  assign o_dz  = r_b == '0;
`else
  assign w_acc = w_msum[WIDTH:1];
  assign w_q   = {w_msum[0], r_q[WIDTH-1:1]};
`endif
  assign o_done = r_busy && r_cnt == CW'(WIDTH - 1);
  assign o_lo   = w_q;
  assign o_hi   = w_acc;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_acc  <= '0;
      r_q    <= '0;
      r_b    <= '0;
`ifdef ALU_SEQ_DIV_EN
      r_div  <= 1'b0;
`endif
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
      r_acc  <= '0;
      r_q    <= i_a;
      r_b    <= i_b;
`ifdef ALU_SEQ_DIV_EN
      r_div  <= i_div;
`endif
    end else if (r_busy) begin
      r_acc  <= w_acc;
      r_q    <= w_q;
      r_cnt  <= r_cnt + CW'(1);
      r_busy <= !o_done;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked multi-cycle ALU; simple ops finish in one cycle, MUL/DIV in WIDTH cycles.
// Define ALU_SEQ_DIV_EN to build the divider; otherwise opcode 3 is illegal.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic [3:0]       flag
);
  state_t             r_state, w_next;
  logic [WIDTH-1:0]   r_out, r_hi;
  logic [3:0]         r_flg;
  logic               w_accept, w_is_mul, w_is_div, w_iter, w_legal, w_done, w_big, w_dz;
  logic [WIDTH-1:0]   w_res, w_lo, w_hi;
  logic [3:0]         w_flg, w_iflg;
  logic [WIDTH:0]     w_add;
  logic [2*WIDTH-1:0] w_shl, w_shr;
  assign w_accept = in_valid && r_state == S_IDLE;
  assign w_is_mul = sel == OP_MUL;
`ifdef ALU_SEQ_DIV_EN
  assign w_is_div = sel == OP_DIV;
  assign w_legal  = sel <= OP_NOR;
`else
  assign w_is_div = 1'b0;
  assign w_legal  = sel <= OP_NOR && sel != OP_DIV;
  assign w_dz     = 1'b0;
`endif
  assign w_iter = w_is_mul || w_is_div;
  assign w_add  = {1'b0, a} + {1'b0, b};
  assign w_big  = b >= WIDTH'(WIDTH);
  assign w_shl  = {{WIDTH{1'b0}}, a} << b;
  assign w_shr  = {a, {WIDTH{1'b0}}} >> b;
  alu_seq_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_start(w_accept && w_iter),
`ifdef ALU_SEQ_DIV_EN
    .i_div  (w_is_div),
    .o_dz   (w_dz),
`endif
    .i_a    (a),
    .i_b    (b),
    .o_done (w_done),
    .o_lo   (w_lo),
    .o_hi   (w_hi)
  );
  always_comb begin
    w_res = '0;
    w_flg = '0;
    case (sel)
      OP_ADD:  begin w_res = w_add[WIDTH-1:0]; w_flg[FLG_CARRY] = w_add[WIDTH]; end
      OP_SUB:  begin w_res = a - b; w_flg[FLG_BORROW] = a < b; end
      OP_SHL:  begin w_res = w_big ? '0 : w_shl[WIDTH-1:0]; w_flg[FLG_CARRY] = w_big ? |a : |w_shl[2*WIDTH-1:WIDTH]; end
      OP_SHR:  begin w_res = w_big ? '0 : w_shr[2*WIDTH-1:WIDTH]; w_flg[FLG_CARRY] = w_big ? |a : |w_shr[WIDTH-1:0]; end
      OP_AND:  w_res = a & b;
      OP_OR:   w_res = a | b;
      OP_XOR:  w_res = a ^ b;
      OP_XNOR: w_res = ~(a ^ b);
      OP_NAND: w_res = ~(a & b);
      OP_NOR:  w_res = ~(a | b);
      default: w_res = '0;
    endcase
    w_flg[FLG_ZERO] = w_legal && w_res == '0;
  end
  // a<b for a nonzero divisor is exactly a zero quotient, so borrow and zero coincide on DIV
  always_comb begin
    w_iflg = '0;
    w_iflg[FLG_ZERO]   = w_lo == '0;
    w_iflg[FLG_OVF]    = r_state == S_MUL ? |w_hi : w_dz;
    w_iflg[FLG_BORROW] = r_state != S_MUL && w_lo == '0;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
`ifdef ALU_SEQ_DIV_EN
      S_IDLE: w_next = !w_accept ? S_IDLE : w_is_mul ? S_MUL : w_is_div ? S_DIV : S_DONE;
      S_DIV:  w_next = w_done ? S_DONE : S_DIV;
`else
      S_IDLE: w_next = !w_accept ? S_IDLE : w_is_mul ? S_MUL : S_DONE;
`endif
      S_MUL:  w_next = w_done ? S_DONE : S_MUL;
      S_DONE: w_next = out_ready ? S_IDLE : S_DONE;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= '0;
      r_hi  <= '0;
      r_flg <= '0;
    end else if (w_accept && !w_iter) begin
      r_out <= w_res;
      r_hi  <= '0;
      r_flg <= w_flg;
    end else if (w_done) begin
      r_out <= w_lo;
      r_hi  <= w_hi;
      r_flg <= w_iflg;
    end
  end
  assign in_ready  = r_state == S_IDLE;
  assign out_valid = r_state == S_DONE;
  assign out       = r_out;
  assign out_hi    = r_hi;
  assign flag      = r_flg;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq (WIDTH=8) against an arithmetic reference model.
module tb_alu_seq;
`ifdef ALU_SEQ_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  logic       clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic [3:0] sel = '0;
  logic       in_ready, out_valid;
  logic [7:0] out, out_hi;
  logic [3:0] flag;
  int n_chk = 0, n_fail = 0;

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .out_hi(out_hi), .flag(flag)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic void model(input int x, input int y, input int op,
                                output int lo, output int hi, output int f, output int lat);
    int r;
    lo = 0; hi = 0; f = 0; lat = 1;
    case (op)
      0: begin r = x + y; lo = r % 256; if (r > 255) f |= 2; end
      1: begin lo = (x - y + 256) % 256; if (x < y) f |= 8; end
      2: begin r = x * y; lo = r % 256; hi = r / 256; if (hi != 0) f |= 4; lat = 9; end
      3: if (DIV_EN) begin
           lat = 9;
           if (y == 0) begin lo = 255; hi = x; f |= 4; end
           else begin lo = x / y; hi = x % y; if (x < y) f |= 8; end
         end
      4: if (y >= 8) begin if (x != 0) f |= 2; end
         else begin r = x * (1 << y); lo = r % 256; if (r > 255) f |= 2; end
      5: if (y >= 8) begin if (x != 0) f |= 2; end
         else begin lo = x / (1 << y); if (x % (1 << y) != 0) f |= 2; end
      6: lo = x & y;
      7: lo = x | y;
      8: lo = x ^ y;
      9: lo = 255 - (x ^ y);
      10: lo = 255 - (x & y);
      11: lo = 255 - (x | y);
      default: lo = 0;
    endcase
    if (op <= 11 && (op != 3 || DIV_EN) && lo == 0) f |= 1;
  endfunction

  task automatic run_op(input int x, input int y, input int op,
                        output int lo, output int hi, output int f, output int lat);
    a = 8'(x); b = 8'(y); sel = 4'(op); in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); sel = 4'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    lo = int'(out); hi = int'(out_hi); f = int'(flag);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out !== 8'd0 || out_hi !== 8'd0 || flag !== 4'd0) begin
      n_fail++;
      $display("FAIL reset: got rdy=%b vld=%b out=%0d hi=%0d flag=%b, expected 1 0 0 0 0000",
               in_ready, out_valid, out, out_hi, flag);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    int ta[12] = '{200, 3, 7, 20, 0, 100, 5, 3, 129, 1, 5, 240};
    int tb[12] = '{100, 5, 7, 20, 255, 7, 0, 9, 1, 9, 5, 15};
    int ts[12] = '{0, 1, 1, 2, 2, 3, 3, 3, 4, 5, 12, 9};
    int el[12] = '{44, 254, 0, 144, 0, DIV_EN ? 14 : 0, DIV_EN ? 255 : 0, 0, 2, 0, 0, 0};
    int eh[12] = '{0, 0, 0, 1, 0, DIV_EN ? 2 : 0, DIV_EN ? 5 : 0, DIV_EN ? 3 : 0, 0, 0, 0, 0};
    int ef[12] = '{2, 8, 1, 4, 1, 0, DIV_EN ? 4 : 0, DIV_EN ? 9 : 0, 2, 3, 0, 1};
    int ec[12] = '{1, 1, 1, 9, 9, DIV_EN ? 9 : 1, DIV_EN ? 9 : 1, DIV_EN ? 9 : 1, 1, 1, 1, 1};
    int lo, hi, f, lat;
    for (int i = 0; i < 12; i++) begin
      run_op(ta[i], tb[i], ts[i], lo, hi, f, lat);
      n_chk++;
      if (lo != el[i] || hi != eh[i] || f != ef[i] || lat != ec[i]) begin
        n_fail++;
        $display("FAIL directed[%0d] op=%0d %0d,%0d: got out=%0d hi=%0d flag=%0d lat=%0d, expected %0d %0d %0d %0d",
                 i, ts[i], ta[i], tb[i], lo, hi, f, lat, el[i], eh[i], ef[i], ec[i]);
      end
    end
  endtask

  task automatic test_random();
    int x, y, op, lo, hi, f, lat, elo, ehi, ef, elat;
    for (int i = 0; i < 150; i++) begin
      op = $urandom_range(0, 15);
      x = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
      y = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 10) : $urandom_range(0, 255);
      model(x, y, op, elo, ehi, ef, elat);
      run_op(x, y, op, lo, hi, f, lat);
      n_chk++;
      if (lo != elo || hi != ehi || f != ef || lat != elat) begin
        n_fail++;
        $display("FAIL random op=%0d %0d,%0d: got out=%0d hi=%0d flag=%0d lat=%0d, expected %0d %0d %0d %0d",
                 op, x, y, lo, hi, f, lat, elo, ehi, ef, elat);
      end
    end
  endtask

  task automatic test_backpressure();
    int x, y, elo, ehi, ef, elat, n;
    x = $urandom_range(16, 255); y = $urandom_range(2, 255);
    model(x, y, 2, elo, ehi, ef, elat);
    a = 8'(x); b = 8'(y); sel = 4'd2; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom); sel = 4'($urandom_range(0, 11));
      n_chk++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || int'(out) != elo || int'(out_hi) != ehi || int'(flag) != ef) begin
        n_fail++;
        $display("FAIL backpressure cycle %0d: got vld=%b rdy=%b out=%0d hi=%0d flag=%0d, expected 1 0 %0d %0d %0d",
                 i, out_valid, in_ready, out, out_hi, flag, elo, ehi, ef);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure release: got vld=%b rdy=%b, expected 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int acc, bad;
    for (int k = 0; k < 2; k++) begin
      a = 8'd20; b = 8'd20; sel = k == 0 ? 4'd0 : 4'd2; in_valid = 1'b1; out_ready = 1'b1;
      acc = 0; bad = 0;
      for (int i = 0; i < 20; i++) begin
        if (in_ready) acc++;
        if (out_valid && (out !== (k == 0 ? 8'd40 : 8'h90) || out_hi !== (k == 0 ? 8'd0 : 8'd1))) bad++;
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
      n_chk++;
      if (acc != (k == 0 ? 10 : 2) || bad != 0) begin
        n_fail++;
        $display("FAIL back_to_back %s: got accepts=%0d bad=%0d, expected %0d 0",
                 k == 0 ? "add" : "mul", acc, bad, k == 0 ? 10 : 2);
      end
      for (int i = 0; i < 20 && !in_ready; i++) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_reset_mid_op();
    int seen;
    a = 8'd100; b = 8'd7; sel = DIV_EN ? 4'd3 : 4'd2; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out !== 8'd0 || out_hi !== 8'd0 || flag !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_mid_op: got vld=%b rdy=%b out=%0d hi=%0d flag=%b, expected 0 1 0 0 0000",
               out_valid, in_ready, out, out_hi, flag);
    end
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 14; i++) begin @(posedge clk); #1; if (out_valid || !in_ready) seen++; end
    n_chk++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL stale_after_reset: got %0d busy/valid cycles, expected 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
